ibuffer_warp_fifo: RTL and testbench



---
 rtl/ibuffer_warp_fifo.sv | 117 +++++++++++
 tb/tb_ibuffer_warp_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer_warp_fifo.sv
// ibuffer_warp_fifo: per-warp instruction buffer holding decoded control-signal
// words between the serializer and the issue stage. It is a circular FIFO of
// DEPTH entries with flush support.
// Optional feature: define IBUFFER_BYPASS_EN so that a word arriving at an
// empty buffer is presented to issue in the same cycle.
module ibuffer_warp_fifo #(
    parameter int BUFFER_WIDTH = 155,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [BUFFER_WIDTH-1:0]    in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [BUFFER_WIDTH-1:0]    out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [BUFFER_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic pushEn;
    logic popEn;

    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_FULL);
    assign in_ready_o = !full_o && !flush_i;

`ifdef IBUFFER_BYPASS_EN
    logic bypassShow;

    // An incoming word at an empty buffer is shown to issue directly.
    assign bypassShow  = empty_o && in_valid_i && !flush_i;
    assign out_valid_o = (!empty_o && !flush_i) || bypassShow;
    assign out_data_o  = bypassShow ? in_data_i : mem_q[rdPtr_q];
`else
    assign out_valid_o = !empty_o && !flush_i;
    assign out_data_o  = mem_q[rdPtr_q];
`endif

    // Handshake decode; a bypassed word taken by issue never touches storage.
    always_comb begin
        pushEn = in_valid_i && in_ready_o;
        popEn  = out_valid_o && out_ready_i;
`ifdef IBUFFER_BYPASS_EN
        if (bypassShow && out_ready_i) begin
            pushEn = 1'b0;
            popEn  = 1'b0;
        end
`endif
    end

    // Next pointer/count values; flush empties the buffer and beats push/pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (pushEn && !popEn) begin
                count_d = count_q + CNT_ONE;
            end else if (popEn && !pushEn) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head word is never X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (pushEn) begin
            mem_q[wrPtr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_ibuffer_warp_fifo.sv
// tb_ibuffer_warp_fifo: directed and randomized stimulus for ibuffer_warp_fifo,
// checked against a queue-based model of the warp buffer plus literal values.
module tb_ibuffer_warp_fifo;

    localparam int W     = 155;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

`ifdef IBUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [W-1:0]  in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [W-1:0]  out_data_o;
    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          full_o;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] modelQ [$];
    bit           modelLive = 1'b0;

    ibuffer_warp_fifo #(.BUFFER_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge and returns at the
    // following falling edge, when the combinational outputs have settled.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic ordy,
                                 input logic fl, input logic r);
        @(posedge clk);
        #1;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        rst         = r;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] randWord();
        logic [159:0] wide;
        wide = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return wide[W-1:0];
    endfunction

    function automatic logic expInReady();
        return (modelQ.size() < DEPTH) && !flush_i;
    endfunction

    function automatic logic expOutValid();
        if (flush_i) return 1'b0;
        return (modelQ.size() > 0) || (BYP && in_valid_i);
    endfunction

    function automatic logic [W-1:0] expOutData();
        if (modelQ.size() > 0) return modelQ[0];
        return in_data_i;
    endfunction

    // Model state update at each rising edge from the inputs present there.
    always @(posedge clk) begin
        logic doPop;
        logic doPush;
        if (rst) begin
            modelQ.delete();
            modelLive = 1'b1;
        end else if (modelLive) begin
            doPop  = expOutValid() && out_ready_i;
            doPush = in_valid_i && expInReady();
            if (flush_i) begin
                modelQ.delete();
            end else if (!(BYP && modelQ.size() == 0 && doPop)) begin
                if (doPop) void'(modelQ.pop_front());
                if (doPush) modelQ.push_back(in_data_i);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("model count_o", W'(count_o), W'(modelQ.size()));
            checkOutput("model empty_o", W'(empty_o), W'(modelQ.size() == 0));
            checkOutput("model full_o", W'(full_o), W'(modelQ.size() == DEPTH));
            checkOutput("model in_ready_o", W'(in_ready_o), W'(expInReady()));
            checkOutput("model out_valid_o", W'(out_valid_o), W'(expOutValid()));
            if (expOutValid()) begin
                checkOutput("model out_data_o", out_data_o, expOutData());
            end
        end
    end

    initial begin
        // Reset and reset-state outputs.
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("reset count", W'(count_o), W'(0));
        checkOutput("reset empty", W'(empty_o), W'(1));
        checkOutput("reset full", W'(full_o), W'(0));
        checkOutput("reset in_ready", W'(in_ready_o), W'(1));
        checkOutput("reset out_valid", W'(out_valid_o), W'(0));
        checkOutput("reset out_data", out_data_o, W'(0));

        // Fill with A1..A4, then offer A5 while full.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, W'(8'hA1 + i), 0, 0, 0);
            checkOutput("fill count", W'(count_o), W'(i));
        end
        checkOutput("fill full", W'(full_o), W'(1));
        checkOutput("fill in_ready", W'(in_ready_o), W'(0));

        // Drain in order; A5 must not appear.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, '0, 1, 0, 0);
            checkOutput("drain data", out_data_o, W'(8'hA1 + i));
            checkOutput("drain valid", W'(out_valid_o), W'(1));
        end
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("drain empty", W'(empty_o), W'(1));
        checkOutput("drain count", W'(count_o), W'(0));

        // Two entries, then push and pop together across pointer wrap.
        applyStimulus(1, W'(8'hB0), 0, 0, 0);
        applyStimulus(1, W'(8'hB1), 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, W'(8'hB2 + i), 1, 0, 0);
            checkOutput("wrap count", W'(count_o), W'(2));
            checkOutput("wrap data", out_data_o, W'(8'hB0 + i));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, '0, 1, 0, 0);
            checkOutput("wrap tail data", out_data_o, W'(8'hB8 + i));
        end

        // Flush with three entries and a push pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, W'(8'hC1 + i), 0, 0, 0);
        end
        applyStimulus(1, W'(8'hC4), 0, 1, 0);
        checkOutput("flush count before", W'(count_o), W'(3));
        checkOutput("flush in_ready", W'(in_ready_o), W'(0));
        checkOutput("flush out_valid", W'(out_valid_o), W'(0));
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("flush count after", W'(count_o), W'(0));
        checkOutput("flush empty", W'(empty_o), W'(1));

        // Reset mid-run with a push pending.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, W'(8'hD1 + i), 0, 0, 0);
        end
        applyStimulus(1, W'(8'hD4), 0, 0, 1);
        checkOutput("midrst count before", W'(count_o), W'(3));
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("midrst count", W'(count_o), W'(0));
        checkOutput("midrst out_valid", W'(out_valid_o), W'(0));
        checkOutput("midrst out_data", out_data_o, W'(0));

        // Word 0x55 arriving at an empty buffer with issue ready.
        applyStimulus(1, W'(8'h55), 1, 0, 0);
`ifdef IBUFFER_BYPASS_EN
        checkOutput("bypass valid", W'(out_valid_o), W'(1));
        checkOutput("bypass data", out_data_o, W'(8'h55));
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("bypass count", W'(count_o), W'(0));
        checkOutput("bypass valid after", W'(out_valid_o), W'(0));
`else
        checkOutput("nobypass valid", W'(out_valid_o), W'(0));
        applyStimulus(0, '0, 0, 0, 0);
        checkOutput("nobypass count", W'(count_o), W'(1));
        checkOutput("nobypass valid after", W'(out_valid_o), W'(1));
        checkOutput("nobypass data after", out_data_o, W'(8'h55));
`endif

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randWord(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
        end
        applyStimulus(0, '0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
